// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : oversampled UART receiver (8N1) feeding a FWFT byte FIFO.
// Optional macro UART_RX_PARITY_EN: 8E1 framing with a parity_err pulse.
// Revision: 1.0
// ============================================================================
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 62500000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIFO_AW:0]   count,
    output logic               overflow,
    input  logic               clr_ovf,
`ifdef UART_RX_PARITY_EN
    output logic               parity_err,
`endif
    output logic               frame_err
);

    localparam int DIV   = CLOCK_FREQ / BAUD_RATE;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic              rx_meta_q, rxs_q, rxs_prev_q;
    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     c_q, c_d;
    logic [2:0]        i_q, i_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic              parity_bad_q, parity_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    logic [7:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        last_q, last_d;

    logic w_push, w_full, w_valid, w_pop, w_wr, w_drop;

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        i_d         = i_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        w_push      = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                    c_d     = '0;
                end
            end
            S_START: begin
                if (c_q == C_HALF) begin
                    c_d     = '0;
                    i_d     = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_DATA: begin
                if (c_q == C_FULL) begin
                    shreg_d[i_q] = rxs_q;
                    c_d          = '0;
                    if (i_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (c_q == C_FULL) begin
                    // Even parity: the parity bit equals the XOR of the data bits.
                    parity_bad_d = rxs_q ^ (^shreg_q);
                    c_d          = '0;
                    state_d      = S_STOP;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (c_q == C_FULL) begin
                    // Return at mid-stop so the next start edge is caught early.
                    state_d = S_IDLE;
                    c_d     = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = parity_bad_q;
                    w_push       = rxs_q && !parity_bad_q;
`else
                    w_push       = rxs_q;
`endif
                    frame_err_d  = !rxs_q;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_full     = count_q[FIFO_AW];
        w_valid    = (count_q != '0);
        w_pop      = w_valid && out_ready;
        w_wr       = w_push && (!w_full || w_pop);
        w_drop     = w_push && w_full && !w_pop;
        wr_ptr_d   = w_wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = w_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        last_d     = w_pop ? mem[rd_ptr_q] : last_q;
        count_d    = count_q;
        if (w_wr && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_wr && w_pop) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = w_drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            c_q          <= '0;
            i_q          <= '0;
            shreg_q      <= '0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            last_q       <= '0;
        end else begin
            rx_meta_q    <= rx;
            rxs_q        <= rx_meta_q;
            rxs_prev_q   <= rxs_q;
            state_q      <= state_d;
            c_q          <= c_d;
            i_q          <= i_d;
            shreg_q      <= shreg_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            last_q       <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wr) begin
            mem[wr_ptr_q] <= shreg_q;
        end
    end

    // When empty, present the most recently popped byte rather than stale memory.
    assign out_data  = w_valid ? mem[rd_ptr_q] : last_q;
    assign out_valid = w_valid;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_fifo : self-checking bench for uart_rx_fifo (DIV = 16).
// Revision: 1.0
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CLOCK_FREQ = 1600;
    localparam int BAUD_RATE  = 100;
    localparam int FIFO_AW    = 4;
    localparam int DIV        = CLOCK_FREQ / BAUD_RATE;
    localparam int DEPTH      = 1 << FIFO_AW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx = 1'b1;
    logic             out_ready = 1'b0;
    logic             clr_ovf = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic [FIFO_AW:0] count;
    logic             overflow;
    logic             frame_err;
`ifdef UART_RX_PARITY_EN
    logic             parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    byte unsigned got_q[$];
    int           got_cyc[$];
    byte unsigned model_q[$];
    bit           model_ovf;

    uart_rx_fifo #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_AW   (FIFO_AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Observes the stream half a cycle before each active edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) valid_cycles++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) perr_cnt++;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (DIV) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(d[k]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) rx = 1'b1;
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    function automatic void model_push(input byte unsigned d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else model_ovf = 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0b want 0", frame_err); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", out_data); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single();
        int f0;
        out_ready = 1'b1;
        got_q.delete();
        valid_cycles = 0;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (4) tick();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_n got %0d want 1", got_q.size()); end
        checks++; if (got_q[0] !== 8'h55) begin errors++; $display("FAIL single_data got %02h want 55", got_q[0]); end
        checks++; if (valid_cycles != 1) begin errors++; $display("FAIL single_vcyc got %0d want 1", valid_cycles); end
        checks++; if (count !== '0) begin errors++; $display("FAIL single_count got %0d want 0", count); end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL single_ferr got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        byte unsigned exp [3];
        exp = '{8'h1B, 8'h5B, 8'h41};
        out_ready = 1'b0;
        got_q.delete();
        got_cyc.delete();
        for (int k = 0; k < 3; k++) send_frame(exp[k], 1'b1, 1'b0);
        repeat (4) tick();
        checks++; if (count !== 5'(3)) begin errors++; $display("FAIL b2b_count got %0d want 3", count); end
        checks++; if (out_data !== 8'h1B) begin errors++; $display("FAIL b2b_head got %02h want 1b", out_data); end
        out_ready = 1'b1;
        repeat (6) tick();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_n got %0d want 3", got_q.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (got_q[k] !== exp[k]) begin errors++; $display("FAIL b2b_data[%0d] got %02h want %02h", k, got_q[k], exp[k]); end
        end
        for (int k = 1; k < 3; k++) begin
            checks++; if (got_cyc[k] != got_cyc[k-1] + 1) begin errors++; $display("FAIL b2b_consec[%0d] got %0d want %0d", k, got_cyc[k], got_cyc[k-1] + 1); end
        end
        checks++; if (count !== '0) begin errors++; $display("FAIL b2b_drain got %0d want 0", count); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        got_q.delete();
        model_q.delete();
        model_ovf = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            send_frame(8'(k), 1'b1, 1'b0);
            model_push(byte'(k));
        end
        repeat (4) tick();
        checks++; if (count !== 5'(model_q.size())) begin errors++; $display("FAIL ovf_count got %0d want %0d", count, model_q.size()); end
        checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL ovf_flag got %0b want %0b", overflow, model_ovf); end
        out_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        checks++; if (got_q.size() != model_q.size()) begin errors++; $display("FAIL ovf_n got %0d want %0d", got_q.size(), model_q.size()); end
        for (int k = 0; k < model_q.size(); k++) begin
            checks++; if (got_q[k] !== model_q[k]) begin errors++; $display("FAIL ovf_data[%0d] got %02h want %02h", k, got_q[k], model_q[k]); end
        end
        checks++; if (out_data !== model_q[model_q.size()-1]) begin errors++; $display("FAIL ovf_hold got %02h want %02h", out_data, model_q[model_q.size()-1]); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        out_ready = 1'b1;
        got_q.delete();
        rx = 1'b0;
        repeat (DIV / 4) tick();
        rx = 1'b1;
        repeat (2 * DIV) tick();
        checks++; if (count !== '0) begin errors++; $display("FAIL glitch_count got %0d want 0", count); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_push got %0d want 0", got_q.size()); end
        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b0);
        repeat (4) tick();
        checks++; if (got_q.size() != 1 || got_q[0] !== d) begin errors++; $display("FAIL glitch_after got %02h want %02h", got_q[0], d); end
    endtask

    task automatic test_frame_err();
        int f0;
        out_ready = 1'b1;
        got_q.delete();
        f0 = ferr_cnt;
        send_frame(8'h41, 1'b0, 1'b0);
        repeat (4) tick();
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - f0); end
        checks++; if (count !== '0 || got_q.size() != 0) begin errors++; $display("FAIL ferr_nopush got %0d want 0", got_q.size()); end
        send_frame(8'h42, 1'b1, 1'b0);
        repeat (4) tick();
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h42) begin errors++; $display("FAIL ferr_next got %02h want 42", got_q[0]); end
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_once got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h7E;
        out_ready = 1'b1;
        got_q.delete();
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) send_bit(d[k]);
        rx = d[4];
        repeat (DIV / 2) tick();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (2) tick();
        checks++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL midrst_state got %0d want 0", count); end
        rst_n = 1'b1;
        repeat (DIV) tick();
        send_frame(8'h31, 1'b1, 1'b0);
        repeat (4) tick();
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h31) begin errors++; $display("FAIL midrst_data got %0d bytes first %02h want 1 byte 31", got_q.size(), got_q[0]); end
`ifdef UART_RX_PARITY_EN
        begin
            int p0;
            p0 = perr_cnt;
            send_frame(8'h31, 1'b1, 1'b1);
            repeat (4) tick();
            checks++; if (perr_cnt - p0 != 1) begin errors++; $display("FAIL parity_pulse got %0d want 1", perr_cnt - p0); end
            checks++; if (got_q.size() != 1) begin errors++; $display("FAIL parity_drop got %0d want 1", got_q.size()); end
        end
`endif
    endtask

    task automatic test_random();
        byte unsigned exp_q[$];
        int f0, exp_ferr;
        bit done;
        got_q.delete();
        f0 = ferr_cnt;
        exp_ferr = 0;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    logic [7:0] d;
                    logic good;
                    d = 8'($urandom);
                    good = ($urandom_range(0, 3) != 0);
                    send_frame(d, good, 1'b0);
                    if (good) exp_q.push_back(d);
                    else exp_ferr++;
                    repeat (good ? $urandom_range(0, DIV) : DIV + $urandom_range(0, DIV)) tick();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_n got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_data[%0d] got %02h want %02h", k, got_q[k], exp_q[k]); end
        end
        checks++; if (ferr_cnt - f0 != exp_ferr) begin errors++; $display("FAIL rand_ferr got %0d want %0d", ferr_cnt - f0, exp_ferr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
